// File: rtl/dfm_pkg.sv
// Shared frequency-meter constants and types used as defaults by the result path.
package dfm_pkg;
  localparam int DFM_CH_NUM     = 5;
  localparam int DFM_DATA_WIDTH = 64;

  typedef logic [DFM_DATA_WIDTH-1:0]     dfm_data_t;
  typedef logic [$clog2(DFM_CH_NUM)-1:0] dfm_ch_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests by the pointer, find first set, unrotate.
module rr_pick #(
  parameter  int CH_NUM = 5,
  localparam int CH_W   = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic              gnt_vld_o,
  output logic [CH_W-1:0]   gnt_idx_o
);
  logic [CH_NUM-1:0] rot;
  int                ffs;
  int                j;
  int                g;

  always_comb begin
    rot = '0;
    j   = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      j = int'(ptr_i) + i;
      if (j >= CH_NUM) j = j - CH_NUM;
      rot[i] = req_i[j[CH_W-1:0]];
    end
  end

  // Scan downward so the lowest set position of the rotated vector wins.
  always_comb begin
    ffs = 0;
    for (int i = CH_NUM - 1; i >= 0; i--)
      if (rot[i]) ffs = i;
    g = int'(ptr_i) + ffs;
    if (g >= CH_NUM) g = g - CH_NUM;
    gnt_vld_o = |rot;
    gnt_idx_o = g[CH_W-1:0];
  end
endmodule

// File: rtl/result_arb.sv
// Per-channel one-entry result buffers drained round-robin into the regfile write port.
// Overflow flags exist only when RESULT_ARB_OVF_EN is defined.
module result_arb
  import dfm_pkg::*;
#(
  parameter  int CH_NUM     = DFM_CH_NUM,
  parameter  int DATA_WIDTH = DFM_DATA_WIDTH,
  localparam int CH_W       = $clog2(CH_NUM)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [CH_NUM-1:0]                ch_wr_en_i,
  input  logic [CH_NUM-1:0][DATA_WIDTH-1:0] ch_wr_data_i,
  input  logic                             reg_wr_rdy_i,
  input  logic                             ovf_clr_i,
  output logic                             reg_wr_en_o,
  output logic [DATA_WIDTH-1:0]            reg_wr_data_o,
  output logic [CH_W-1:0]                  reg_wr_ch_o,
  output logic [CH_NUM-1:0]                ovf_o
);
  logic [CH_NUM-1:0]                 pend_vld;
  logic [CH_NUM-1:0][DATA_WIDTH-1:0] pend_data;
  logic [CH_W-1:0]                   rr_ptr;
  logic                              gnt_vld;
  logic [CH_W-1:0]                   gnt_idx;
  logic                              free;
  logic                              do_gnt;
  logic [CH_NUM-1:0]                 gnt_hit;

  rr_pick #(.CH_NUM(CH_NUM)) u_pick (
    .req_i     (pend_vld),
    .ptr_i     (rr_ptr),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  assign free   = !reg_wr_en_o || reg_wr_rdy_i;
  assign do_gnt = free && gnt_vld;

  always_comb begin
    gnt_hit = '0;
    for (int c = 0; c < CH_NUM; c++)
      gnt_hit[c] = do_gnt && (gnt_idx == CH_W'(c));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_vld      <= '0;
      pend_data     <= '0;
      rr_ptr        <= '0;
      reg_wr_en_o   <= 1'b0;
      reg_wr_data_o <= '0;
      reg_wr_ch_o   <= '0;
    end else begin
      // A strobe always refills its slot, even when the old word is granted this cycle.
      for (int c = 0; c < CH_NUM; c++) begin
        if (ch_wr_en_i[c]) begin
          pend_vld[c]  <= 1'b1;
          pend_data[c] <= ch_wr_data_i[c];
        end else if (gnt_hit[c]) begin
          pend_vld[c]  <= 1'b0;
        end
      end
      if (free) begin
        reg_wr_en_o <= gnt_vld;
        if (gnt_vld) begin
          reg_wr_data_o <= pend_data[gnt_idx];
          reg_wr_ch_o   <= gnt_idx;
          rr_ptr        <= (gnt_idx == CH_W'(CH_NUM - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

`ifdef RESULT_ARB_OVF_EN
  logic [CH_NUM-1:0] ovf_q;
  logic [CH_NUM-1:0] ovf_set;

  assign ovf_set = ch_wr_en_i & pend_vld & ~gnt_hit;

  // New overflow in the clear cycle still lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= '0;
    else       ovf_q <= (ovf_clr_i ? '0 : ovf_q) | ovf_set;
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr_i;
  assign ovf_o          = '0;
`endif
endmodule

// File: tb/tb_result_arb.sv
// Scoreboard bench for result_arb: directed scenarios then randomized traffic vs a slot model.
module tb_result_arb;
  import dfm_pkg::*;
  localparam int N = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  rdy = 1'b0;
  logic                  clr = 1'b0;
  logic [N-1:0]          wr_en = '0;
  logic [N-1:0][63:0]    wr_data = '0;
  logic                  en_o;
  logic [63:0]           data_o;
  logic [2:0]            ch_o;
  logic [N-1:0]          ovf_o;

  result_arb dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ch_wr_en_i    (wr_en),
    .ch_wr_data_i  (wr_data),
    .reg_wr_rdy_i  (rdy),
    .ovf_clr_i     (clr),
    .reg_wr_en_o   (en_o),
    .reg_wr_data_o (data_o),
    .reg_wr_ch_o   (ch_o),
    .ovf_o         (ovf_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: slots, pointer, output-valid and flags; words expected downstream go to sb.
  bit           m_vld[N];
  dfm_data_t    m_data[N];
  int           m_ptr = 0;
  bit           c_en = 0, n_en = 0;
  logic [N-1:0] c_ovf = '0, n_ovf = '0;
  logic [66:0]  sb[$];
  dfm_data_t    s_data[N];
  bit           mon_on = 0;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic [N-1:0] e, input logic r, input logic cl, input logic rs);
    int g;
    logic [N-1:0] ovs;
    g   = -1;
    ovs = '0;
    if (rs) begin
      for (int c = 0; c < N; c++) m_vld[c] = 0;
      m_ptr = 0;
      n_en  = 0;
      n_ovf = '0;
      sb.delete();
      return;
    end
    if (!c_en || r) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && m_vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      n_en = (g >= 0);
      if (g >= 0) begin
        sb.push_back({3'(g), m_data[g]});
        m_ptr = (g + 1) % N;
      end
    end else begin
      n_en = c_en;
    end
    for (int c = 0; c < N; c++) begin
      if (e[c]) begin
        if (m_vld[c] && c != g) ovs[c] = 1'b1;
        m_vld[c]  = 1;
        m_data[c] = s_data[c];
      end else if (c == g) begin
        m_vld[c] = 0;
      end
    end
`ifdef RESULT_ARB_OVF_EN
    n_ovf = (cl ? '0 : c_ovf) | ovs;
`else
    n_ovf = '0;
`endif
  endtask

  task automatic tick(input logic [N-1:0] e, input logic r, input logic cl, input logic rs);
    @(posedge clk);
    #1;
    c_en  = n_en;
    c_ovf = n_ovf;
    wr_en = e;
    rdy   = r;
    clr   = cl;
    rst   = rs;
    for (int c = 0; c < N; c++) wr_data[c] = s_data[c];
    model_step(e, r, cl, rs);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) tick('0, r, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_en"},   67'(en_o),   67'(0));
    check({tag, "_data"}, 67'(data_o), 67'(0));
    check({tag, "_ch"},   67'(ch_o),   67'(0));
    check({tag, "_ovf"},  67'(ovf_o),  67'(0));
  endtask

  // Monitor: sampled mid-cycle; a word is consumed when valid and ready meet.
  always @(negedge clk) begin
    logic [66:0] exp;
    if (mon_on) begin
      check("en", 67'(en_o), 67'(c_en));
      check("ovf", 67'(ovf_o), 67'(c_ovf));
      if (en_o && rdy && !rst) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got ch %0d data %h want no word", ch_o, data_o);
        end else begin
          exp = sb.pop_front();
          check("word", {ch_o, data_o}, exp);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] e;
    for (int c = 0; c < N; c++) begin
      s_data[c] = '0;
      m_vld[c]  = 0;
      m_data[c] = '0;
    end
    tick('0, 1'b0, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b0, 1'b1);
    tick('0, 1'b1, 1'b0, 1'b0);
    mon_on = 1;
    chk_zero("reset");

    // Single uncontended result on ch 2
    s_data[2] = 64'h0000_0000_0001_86A0;
    tick(5'b00100, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);

    // Move pointer to 0, then all five at once
    s_data[4] = 64'h1;
    tick(5'b10000, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    for (int c = 0; c < N; c++) s_data[c] = 64'h10 + 64'(c);
    tick(5'b11111, 1'b1, 1'b0, 1'b0);
    idle(7, 1'b1);

    // ch0+ch4 with pointer 0, then with pointer 1
    s_data[0] = 64'h20; s_data[4] = 64'h24;
    tick(5'b10001, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    s_data[0] = 64'h30;
    tick(5'b00001, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    s_data[0] = 64'h40; s_data[4] = 64'h44;
    tick(5'b10001, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);

    // Stall with ch 1 word on the output, refill then overflow the slot
    s_data[1] = 64'h55;
    tick(5'b00010, 1'b1, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2)      begin s_data[1] = 64'h66; e = 5'b00010; end
      else if (i == 5) begin s_data[1] = 64'h77; e = 5'b00010; end
      else             e = '0;
      tick(e, 1'b0, 1'b0, 1'b0);
      check("stall_hold", 67'(data_o), 67'(64'h55));
    end
    idle(4, 1'b1);

    // Grant and refill of ch 3 in one cycle, clearing flags meanwhile
    s_data[3] = 64'hA;
    tick(5'b01000, 1'b1, 1'b0, 1'b0);
    s_data[3] = 64'hB;
    tick(5'b01000, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Reset with three pending slots behind a stalled word
    s_data[1] = 64'h99;
    tick(5'b00010, 1'b1, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);
    s_data[0] = 64'hC0; s_data[2] = 64'hC2; s_data[4] = 64'hC4;
    tick(5'b10101, 1'b0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b1);
    tick('0, 1'b1, 1'b0, 1'b0);
    chk_zero("midrst");
    idle(6, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        s_data[c] = {$urandom, $urandom};
        e[c]      = ($urandom_range(3) == 0);
      end
      tick(e, $urandom_range(3) != 0, $urandom_range(49) == 0, 1'b0);
    end
    idle(10, 1'b1);
    @(negedge clk);
    #1;
    check("sb_drained", 67'(sb.size()), 67'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
